// File: rtl/tick_monitor.sv
// Measures rise-to-rise spacing of a one-cycle tick, checks it against NOMINAL +/- TOL,
// and reports lock, misses, timeouts and the measured period over a valid/ready port.
module tick_monitor #(
    parameter int WIDTH      = 21,
    parameter int NOMINAL    = 625001,
    parameter int TOL        = 16,
    parameter int TIMEOUT    = 1250002,
    parameter int LOCK_COUNT = 2
) (
    input  logic             fastclock,
    input  logic             reset_n,
    input  logic             tick_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             locked,
    output logic             timeout,
    output logic             overrun,
    output logic [7:0]       miss_count
);

    localparam int GW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] PERIOD_LO = WIDTH'(NOMINAL - TOL);
    localparam logic [WIDTH-1:0] PERIOD_HI = WIDTH'(NOMINAL + TOL);
    localparam logic [WIDTH-1:0] CNT_TMO   = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [GW-1:0]    GOOD_MAX  = GW'(LOCK_COUNT);

    typedef enum logic {
        SEEK = 1'b0,
        MEAS = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             tick_d;
    logic             rise;
    logic             capture;
    logic             expire;
    logic             in_range;
    logic [WIDTH-1:0] cnt;
    logic [GW-1:0]    good_run;
    logic [GW-1:0]    good_next;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [GW-1:0] sat_inc_good(input logic [GW-1:0] v);
        return (v >= GOOD_MAX) ? GOOD_MAX : v + GW'(1);
    endfunction

    assign rise      = tick_in & ~tick_d;
    assign in_range  = (cnt >= PERIOD_LO) && (cnt <= PERIOD_HI);
    assign good_next = sat_inc_good(good_run);

    // A rise that coincides with cnt == TIMEOUT is a measurement, not a timeout.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        expire     = 1'b0;
        case (state)
            SEEK: begin
                if (rise) state_next = MEAS;
            end
            MEAS: begin
                if (rise) begin
                    capture = 1'b1;
                end else if (cnt == CNT_TMO) begin
                    expire     = 1'b1;
                    state_next = SEEK;
                end
            end
            default: state_next = SEEK;
        endcase
    end

    always_ff @(posedge fastclock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEEK;
        end else begin
            state <= state_next;
        end
    end

    // cnt reads as the rise-to-rise distance on the cycle of the next rise.
    always_ff @(posedge fastclock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= WIDTH'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    always_ff @(posedge fastclock or negedge reset_n) begin
        if (!reset_n) begin
            tick_d       <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
            overrun      <= 1'b0;
            miss_count   <= 8'd0;
            good_run     <= '0;
        end else begin
            tick_d  <= tick_in;
            timeout <= expire;
            if (capture) begin
                period       <= cnt;
                period_valid <= 1'b1;
                if (period_valid && !period_ready) overrun <= 1'b1;
                if (in_range) begin
                    good_run <= good_next;
                    if (good_next == GOOD_MAX) locked <= 1'b1;
                end else begin
                    good_run   <= '0;
                    locked     <= 1'b0;
                    miss_count <= sat_inc8(miss_count);
                end
            end else begin
                if (period_valid && period_ready) period_valid <= 1'b0;
                if (expire) begin
                    good_run   <= '0;
                    locked     <= 1'b0;
                    miss_count <= sat_inc8(miss_count);
                end
            end
        end
    end

endmodule
